// File: rtl/ob_pkg.sv
// Shared order-book types: commands, responses and the in-flight tag entry
// used by the multi-channel command arbiter.
package ob_pkg;

    typedef enum logic [2:0] {
        Op_Nop       = 3'd0,
        Op_Buy       = 3'd1,
        Op_Sell      = 3'd2,
        Op_Cancel    = 3'd3,
        Op_QryBidAsk = 3'd4
    } op_t;

    typedef logic [7:0] uid_t;

    typedef struct packed {
        op_t         op;
        uid_t        uid;
        logic [15:0] qty;
        logic [15:0] price;
    } cmd_t;

    typedef struct packed {
        uid_t        uid;
        logic [1:0]  status;
        logic [15:0] data;
    } rsp_t;

    localparam int CMD_W = $bits(cmd_t);
    localparam int RSP_W = $bits(rsp_t);

    // Channel ids are sized for the largest supported arbiter so the tag
    // entry layout does not change with the instance's channel count.
    localparam int OB_ARB_N_CH_MAX = 16;
    typedef logic [$clog2(OB_ARB_N_CH_MAX)-1:0] ch_id_t;

    typedef struct packed {
        logic   vld;
        uid_t   uid;
        ch_id_t ch;
    } tag_entry_t;

endpackage

// File: rtl/ob_cmd_arb_fifo.sv
// Per-channel ingress FIFO of commands. Full is registered but computed from
// next-state occupancy, so it is exact every cycle. A push while full is
// dropped and latched in a sticky overflow flag, unless a pop happens in the
// same cycle, in which case the pop frees the slot first.
module ob_cmd_arb_fifo
    import ob_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic empty,
    output logic full_r,
    output logic ovf_r
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok    = pop && (count != '0);
    assign push_ok   = push && (!full_r || pop_ok);
    assign count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    assign head      = mem[rd_ptr];
    assign empty     = (count == '0);

    // Pointer, occupancy, full and overflow bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            full_r <= (count_nxt == CNT_W'(DEPTH));
            if (push && full_r && !pop_ok) ovf_r <= 1'b1;
        end
    end

    // Storage write; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ob_cmd_arb.sv
// Multi-channel command front-end for the order book. Commands from N_CH
// producers queue in per-channel FIFOs, are issued round-robin to `ob` with a
// tag allocated per command, and each `ob` response is routed back to the
// issuing channel by uid lookup in the tag table.
//
// Handshakes: ch_cmd_vld_r is a push that is accepted unless the channel is
// full; ob_cmd_vld_r is a one-cycle pulse issued only while ob_cmd_full_r is
// low; a response transfers on ob_rsp_vld && ob_rsp_accept, and a channel
// response transfers on ch_rsp_vld && ch_rsp_accept.
module ob_cmd_arb
    import ob_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DEPTH    = 4,
    parameter int INFLIGHT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               ch_cmd_vld_r,
    input  logic [N_CH*CMD_W-1:0]         ch_cmd_r,
    output logic [N_CH-1:0]               ch_cmd_full_r,
    input  logic [N_CH-1:0]               ch_rsp_accept,
    output logic [N_CH-1:0]               ch_rsp_vld,
    output logic [N_CH*RSP_W-1:0]         ch_rsp,
    output logic                          ob_cmd_vld_r,
    output logic [CMD_W-1:0]              ob_cmd_r,
    input  logic                          ob_cmd_full_r,
    input  logic                          ob_rsp_vld,
    input  logic [RSP_W-1:0]              ob_rsp,
    output logic                          ob_rsp_accept,
    output logic [N_CH-1:0]               err_ovf_r,
    output logic                          err_unmatched_r,
    output logic [$clog2(INFLIGHT+1)-1:0] inflight_cnt_r
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TAG_W = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
    localparam int CNT_W = $clog2(INFLIGHT + 1);

    cmd_t             head [N_CH];
    logic [N_CH-1:0]  empty;
    logic [N_CH-1:0]  pop;
    logic [N_CH-1:0]  busy;
    logic [N_CH-1:0]  elig;
    tag_entry_t       tags [INFLIGHT];
    logic             have_free;
    logic [TAG_W-1:0] free_idx;
    logic [CH_W-1:0]  rr_ptr;
    logic             grant_vld;
    logic [CH_W-1:0]  grant_idx;
    rsp_t             rsp_in;
    logic             rsp_hit;
    logic [TAG_W-1:0] hit_idx;
    ch_id_t           hit_ch;
    logic [CH_W-1:0]  hit_sel;
    logic             rsp_load;
    rsp_t             rsp_q [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ob_cmd_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (ch_cmd_vld_r[g]),
            .push_data (cmd_t'(ch_cmd_r[g*CMD_W +: CMD_W])),
            .pop       (pop[g]),
            .head      (head[g]),
            .empty     (empty[g]),
            .full_r    (ch_cmd_full_r[g]),
            .ovf_r     (err_ovf_r[g])
        );
        assign ch_rsp[g*RSP_W +: RSP_W] = rsp_q[g];
    end

    // A head whose uid is already outstanding must wait: uids stay unique at `ob`.
    always_comb begin
        busy = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int t = 0; t < INFLIGHT; t++) begin
                if (tags[t].vld && (tags[t].uid == head[c].uid)) busy[c] = 1'b1;
            end
        end
    end

    // Lowest-index free tag.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int t = INFLIGHT - 1; t >= 0; t--) begin
            if (!tags[t].vld) begin
                have_free = 1'b1;
                free_idx  = TAG_W'(t);
            end
        end
    end

    assign elig = ~empty & ~busy & {N_CH{have_free & ~ob_cmd_full_r}};

    // Round-robin search starting at the pointer; first eligible channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!grant_vld && elig[(int'(rr_ptr) + k) % N_CH]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'((int'(rr_ptr) + k) % N_CH);
            end
        end
    end

    // Pop exactly the granted FIFO.
    always_comb begin
        pop = '0;
        if (grant_vld) pop[grant_idx] = 1'b1;
    end

    // Register the issued command and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ob_cmd_vld_r <= 1'b0;
            ob_cmd_r     <= '0;
            rr_ptr       <= '0;
        end else begin
            ob_cmd_vld_r <= grant_vld;
            if (grant_vld) begin
                ob_cmd_r <= head[grant_idx];
                rr_ptr   <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign rsp_in = rsp_t'(ob_rsp);

    // Uid lookup of the incoming response against the valid tags.
    always_comb begin
        rsp_hit = 1'b0;
        hit_idx = '0;
        hit_ch  = '0;
        for (int t = 0; t < INFLIGHT; t++) begin
            if (tags[t].vld && (tags[t].uid == rsp_in.uid)) begin
                rsp_hit = 1'b1;
                hit_idx = TAG_W'(t);
                hit_ch  = tags[t].ch;
            end
        end
    end

    assign hit_sel = CH_W'(hit_ch);

    // Matched responses wait for room in the channel register; misses are always taken.
    always_comb begin
        ob_rsp_accept = 1'b0;
        if (ob_rsp_vld) begin
            ob_rsp_accept = rsp_hit ? (!ch_rsp_vld[hit_sel] || ch_rsp_accept[hit_sel]) : 1'b1;
        end
    end

    assign rsp_load = ob_rsp_vld && rsp_hit && ob_rsp_accept;

    // Tag table: free on an accepted response, allocate on grant; the two never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < INFLIGHT; t++) tags[t] <= '0;
            inflight_cnt_r  <= '0;
            err_unmatched_r <= 1'b0;
        end else begin
            if (rsp_load) tags[hit_idx].vld <= 1'b0;
            if (grant_vld) begin
                tags[free_idx].vld <= 1'b1;
                tags[free_idx].uid <= head[grant_idx].uid;
                tags[free_idx].ch  <= ch_id_t'(grant_idx);
            end
            inflight_cnt_r <= inflight_cnt_r + CNT_W'(grant_vld) - CNT_W'(rsp_load);
            if (ob_rsp_vld && !rsp_hit) err_unmatched_r <= 1'b1;
        end
    end

    // Per-channel one-entry response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_rsp_vld <= '0;
            for (int c = 0; c < N_CH; c++) rsp_q[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (rsp_load && (hit_sel == CH_W'(c))) begin
                    ch_rsp_vld[c] <= 1'b1;
                    rsp_q[c]      <= rsp_in;
                end else if (ch_rsp_accept[c]) begin
                    ch_rsp_vld[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ob_cmd_arb.sv
// Directed bench for ob_cmd_arb with per-channel command and response
// scoreboards fed by the driver tasks and drained by two output monitors.
module tb_ob_cmd_arb;
    import ob_pkg::*;

    localparam int N_CH     = 4;
    localparam int DEPTH    = 4;
    localparam int INFLIGHT = 8;
    localparam int CNT_W    = $clog2(INFLIGHT + 1);

    logic                  clk;
    logic                  rst;
    logic [N_CH-1:0]       ch_cmd_vld_r;
    logic [N_CH*CMD_W-1:0] ch_cmd_r;
    logic [N_CH-1:0]       ch_cmd_full_r;
    logic [N_CH-1:0]       ch_rsp_accept;
    logic [N_CH-1:0]       ch_rsp_vld;
    logic [N_CH*RSP_W-1:0] ch_rsp;
    logic                  ob_cmd_vld_r;
    logic [CMD_W-1:0]      ob_cmd_r;
    logic                  ob_cmd_full_r;
    logic                  ob_rsp_vld;
    logic [RSP_W-1:0]      ob_rsp;
    logic                  ob_rsp_accept;
    logic [N_CH-1:0]       err_ovf_r;
    logic                  err_unmatched_r;
    logic [CNT_W-1:0]      inflight_cnt_r;

    ob_cmd_arb #(.N_CH(N_CH), .DEPTH(DEPTH), .INFLIGHT(INFLIGHT)) dut (
        .clk             (clk),
        .rst             (rst),
        .ch_cmd_vld_r    (ch_cmd_vld_r),
        .ch_cmd_r        (ch_cmd_r),
        .ch_cmd_full_r   (ch_cmd_full_r),
        .ch_rsp_accept   (ch_rsp_accept),
        .ch_rsp_vld      (ch_rsp_vld),
        .ch_rsp          (ch_rsp),
        .ob_cmd_vld_r    (ob_cmd_vld_r),
        .ob_cmd_r        (ob_cmd_r),
        .ob_cmd_full_r   (ob_cmd_full_r),
        .ob_rsp_vld      (ob_rsp_vld),
        .ob_rsp          (ob_rsp),
        .ob_rsp_accept   (ob_rsp_accept),
        .err_ovf_r       (err_ovf_r),
        .err_unmatched_r (err_unmatched_r),
        .inflight_cnt_r  (inflight_cnt_r)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int                n_checks = 0;
    int                n_fail   = 0;
    int                issue_cnt = 0;
    int                uid_ch [256];
    logic [CMD_W-1:0]  cmd_exp_q [N_CH][$];
    logic [RSP_W-1:0]  rsp_exp_q [N_CH][$];
    int                grant_log [$];
    logic [7:0]        out_q [$];
    cmd_t              ob_cmd_s;
    cmd_t              mon_hd;
    int                mon_found;
    logic              rsp_pending;

    assign ob_cmd_s = cmd_t'(ob_cmd_r);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        ch_cmd_vld_r = '0;
    endtask

    function automatic cmd_t mk_cmd(input op_t op, input logic [7:0] uid);
        cmd_t c;
        c.op    = op;
        c.uid   = uid;
        c.qty   = 16'($urandom_range(1, 1000));
        c.price = 16'($urandom_range(0, 65535));
        return c;
    endfunction

    task automatic drive_cmd(input int ch, input cmd_t cmd, input bit exp_acc);
        ch_cmd_vld_r[ch]             = 1'b1;
        ch_cmd_r[ch*CMD_W +: CMD_W]  = cmd;
        uid_ch[cmd.uid]              = ch;
        if (exp_acc) cmd_exp_q[ch].push_back(cmd);
    endtask

    task automatic send_rsp(input logic [7:0] uid, input bit exp_hit);
        rsp_t r;
        int   n;
        r.uid      = uid;
        r.status   = 2'($urandom_range(0, 3));
        r.data     = 16'($urandom_range(0, 65535));
        ob_rsp     = r;
        ob_rsp_vld = 1'b1;
        #1;
        if (!exp_hit) check("unmatched_accept", ob_rsp_accept, 1);
        n = 0;
        while (!ob_rsp_accept && n < 20) begin
            cycle();
            n++;
        end
        check("rsp_accept_wait", ob_rsp_accept, 1);
        if (exp_hit && ob_rsp_accept) rsp_exp_q[uid_ch[uid]].push_back(r);
        cycle();
        ob_rsp_vld = 1'b0;
    endtask

    task automatic wait_issues(input int target);
        int n;
        n = 0;
        while (issue_cnt < target && n < 60) begin
            cycle();
            n++;
        end
        check("issue_wait", issue_cnt, target);
    endtask

    task automatic drain_all();
        while (out_q.size() > 0) send_rsp(out_q.pop_front(), 1'b1);
        cycle();
    endtask

    task automatic flush_model();
        for (int c = 0; c < N_CH; c++) begin
            cmd_exp_q[c].delete();
            rsp_exp_q[c].delete();
        end
        out_q.delete();
        grant_log.delete();
    endtask

    task automatic apply_reset();
        rst           = 1'b0;
        ch_cmd_vld_r  = '0;
        ch_cmd_r      = '0;
        ch_rsp_accept = '1;
        ob_cmd_full_r = 1'b0;
        ob_rsp_vld    = 1'b0;
        ob_rsp        = '0;
        flush_model();
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
    endtask

    // ---------------- monitors ----------------
    // Issued commands must be the head of some channel's expected queue.
    always @(negedge clk) begin
        if (rst && ob_cmd_vld_r) begin
            mon_found = -1;
            for (int c = 0; c < N_CH; c++) begin
                if (mon_found < 0 && cmd_exp_q[c].size() > 0) begin
                    mon_hd = cmd_exp_q[c][0];
                    if (mon_hd.uid == ob_cmd_s.uid) mon_found = c;
                end
            end
            check("cmd_known", mon_found >= 0, 1);
            if (mon_found >= 0) begin
                check("cmd_data", ob_cmd_r, cmd_exp_q[mon_found].pop_front());
                grant_log.push_back(mon_found);
                out_q.push_back(ob_cmd_s.uid);
            end
            issue_cnt++;
        end
    end

    // Consumed channel responses must match the expected per-channel stream.
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_rsp_vld[c] && ch_rsp_accept[c]) begin
                    rsp_pending = (rsp_exp_q[c].size() != 0);
                    check("rsp_expected", rsp_pending, 1);
                    if (rsp_pending) check("rsp_data", ch_rsp[c*RSP_W +: RSP_W], rsp_exp_q[c].pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int left;

        // Reset state
        apply_reset();
        rst = 1'b0;
        #1;
        check("rst_full", ch_cmd_full_r, 0);
        check("rst_rsp_vld", ch_rsp_vld, 0);
        check("rst_cmd_vld", ob_cmd_vld_r, 0);
        check("rst_ovf", err_ovf_r, 0);
        check("rst_unm", err_unmatched_r, 0);
        check("rst_inflight", inflight_cnt_r, 0);
        apply_reset();

        // Single command on ch1, latency and response routing
        drive_cmd(1, mk_cmd(Op_Buy, 8'd5), 1'b1);
        cycle();
        check("t1_no_fallthrough", ob_cmd_vld_r, 0);
        cycle();
        check("t1_issue", ob_cmd_vld_r, 1);
        check("t1_uid", ob_cmd_s.uid, 5);
        check("t1_inflight1", inflight_cnt_r, 1);
        cycle();
        check("t1_pulse", ob_cmd_vld_r, 0);
        out_q.delete();
        send_rsp(8'd5, 1'b1);
        check("t1_rsp_vld", ch_rsp_vld, 4'b0010);
        check("t1_inflight0", inflight_cnt_r, 0);
        cycle();

        // Round-robin across all channels, then tag-table exhaustion
        apply_reset();
        base = issue_cnt;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                op_t op;
                op = (c == 1) ? Op_Nop : (c == 3) ? Op_QryBidAsk : (k == 0) ? Op_Buy : Op_Sell;
                drive_cmd(c, mk_cmd(op, 8'(16 * c + k + 1)), 1'b1);
            end
            cycle();
        end
        wait_issues(base + 8);
        for (int i = 0; i < 8; i++) check($sformatf("t2_grant%0d", i), grant_log[i], i % N_CH);
        check("t2_no_ovf", err_ovf_r, 0);
        check("t4_inflight_full", inflight_cnt_r, 8);
        drive_cmd(0, mk_cmd(Op_Cancel, 8'h50), 1'b1);
        repeat (5) cycle();
        check("t4_halt", issue_cnt, base + 8);
        send_rsp(out_q.pop_front(), 1'b1);
        wait_issues(base + 9);
        repeat (4) cycle();
        check("t4_one_more", issue_cnt, base + 9);
        check("t4_inflight_still_full", inflight_cnt_r, 8);
        drain_all();
        check("t4_drained", inflight_cnt_r, 0);

        // Overflow on ch0 while `ob` is full, then pop+push while full
        apply_reset();
        base = issue_cnt;
        ob_cmd_full_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_cmd(0, mk_cmd(Op_Buy, 8'(8'h20 + k)), 1'b1);
            cycle();
            if (k == 2) check("t3_not_full", ch_cmd_full_r[0], 0);
        end
        check("t3_full", ch_cmd_full_r[0], 1);
        check("t3_no_ovf_yet", err_ovf_r, 0);
        drive_cmd(0, mk_cmd(Op_Buy, 8'h24), 1'b0);
        cycle();
        check("t3_ovf", err_ovf_r, 4'b0001);
        check("t3_still_full", ch_cmd_full_r[0], 1);
        ob_cmd_full_r = 1'b0;
        drive_cmd(0, mk_cmd(Op_Sell, 8'h25), 1'b1);
        cycle();
        check("t3_popush_full", ch_cmd_full_r[0], 1);
        wait_issues(base + 5);
        check("t3_empty_full", ch_cmd_full_r[0], 0);
        check("t3_ovf_sticky", err_ovf_r, 4'b0001);
        drain_all();

        // Response backpressure on ch2 and an unmatched response
        apply_reset();
        base = issue_cnt;
        ch_rsp_accept[2] = 1'b0;
        drive_cmd(2, mk_cmd(Op_Buy, 8'd40), 1'b1);
        cycle();
        drive_cmd(2, mk_cmd(Op_Sell, 8'd41), 1'b1);
        wait_issues(base + 2);
        out_q.delete();
        send_rsp(8'd40, 1'b1);
        check("t5_held", ch_rsp_vld[2], 1);
        begin
            rsp_t r;
            r.uid      = 8'd41;
            r.status   = 2'd1;
            r.data     = 16'($urandom_range(0, 65535));
            ob_rsp     = r;
            ob_rsp_vld = 1'b1;
            #1;
            check("t5_bp0", ob_rsp_accept, 0);
            cycle();
            check("t5_bp1", ob_rsp_accept, 0);
            check("t5_inflight", inflight_cnt_r, 1);
            ch_rsp_accept[2] = 1'b1;
            #1;
            check("t5_accept", ob_rsp_accept, 1);
            rsp_exp_q[2].push_back(r);
            cycle();
            ob_rsp_vld = 1'b0;
        end
        check("t5_reload", ch_rsp_vld[2], 1);
        check("t5_inflight0", inflight_cnt_r, 0);
        send_rsp(8'd99, 1'b0);
        check("t5_unmatched", err_unmatched_r, 1);

        // Reset in the middle of traffic with three commands outstanding
        base = issue_cnt;
        drive_cmd(0, mk_cmd(Op_Buy, 8'd70), 1'b1);
        drive_cmd(1, mk_cmd(Op_Sell, 8'd71), 1'b1);
        drive_cmd(3, mk_cmd(Op_Cancel, 8'd72), 1'b1);
        cycle();
        wait_issues(base + 3);
        check("t6_inflight3", inflight_cnt_r, 3);
        ob_cmd_full_r = 1'b1;
        drive_cmd(0, mk_cmd(Op_Buy, 8'd73), 1'b1);
        cycle();
        rst = 1'b0;
        #1;
        check("t6_full0", ch_cmd_full_r, 0);
        check("t6_rsp_vld0", ch_rsp_vld, 0);
        check("t6_cmd_vld0", ob_cmd_vld_r, 0);
        check("t6_ovf0", err_ovf_r, 0);
        check("t6_unm0", err_unmatched_r, 0);
        check("t6_inflight0", inflight_cnt_r, 0);
        flush_model();
        cycle();
        rst = 1'b1;
        ob_cmd_full_r = 1'b0;
        base = issue_cnt;
        repeat (5) cycle();
        check("t6_queue_discarded", issue_cnt, base);
        send_rsp(8'd70, 1'b0);
        check("t6_unmatched", err_unmatched_r, 1);
        repeat (3) cycle();

        left = 0;
        for (int c = 0; c < N_CH; c++) left += cmd_exp_q[c].size() + rsp_exp_q[c].size();
        check("leftover_expected", left, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
